// File: rtl/cache_mgmt_unit.sv
// Cache controller between CPU memory stage, 2-way data cache and main memory: hits answer the cycle after the
// lookup, misses stall through dirty write-back and 4-beat refill; optional perf counters under CMU_PERF_CNT_EN.
module cache_mgmt_unit #(
  parameter int ADDR_BITS  = 32,
  parameter int TAG_BITS   = 23,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_r,
  input  logic                 en_w,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          data_w,
  output logic [31:0]          data_r,
  output logic                 stall,
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_load,
  output logic                 cache_edit,
  output logic                 cache_store,
  output logic                 cache_invalid,
  output logic [2:0]           cache_u_b_h_w,
  output logic [31:0]          cache_din,
  input  logic                 cache_hit,
  input  logic [31:0]          cache_dout,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_dout,
  input  logic [31:0]          mem_din,
  input  logic                 mem_ack,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt,
  output logic [31:0]          wb_cnt
);

  localparam int CNT_BITS = $clog2(LINE_WORDS);
  localparam int IDX_LSB  = CNT_BITS + 2;
  localparam int IDX_MSB  = ADDR_BITS - TAG_BITS - 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(LINE_WORDS - 1);
  localparam logic [2:0] WIDTH_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_BACK,
    S_FILL,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_BITS-1:0] req_addr;
  logic [2:0]           req_type;
  logic                 req_w;
  logic [31:0]          req_data;
  logic [TAG_BITS-1:0]  victim_tag;
  logic [CNT_BITS-1:0]  cnt;
  logic                 phase;
  logic                 replay;

  logic [ADDR_BITS-1:0] back_addr;
  logic [ADDR_BITS-1:0] fill_addr;

  assign back_addr = {victim_tag, req_addr[IDX_MSB:IDX_LSB], cnt, 2'b00};
  assign fill_addr = {req_addr[ADDR_BITS-1:IDX_MSB+1], req_addr[IDX_MSB:IDX_LSB], cnt, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_addr   <= '0;
      req_type   <= '0;
      req_w      <= 1'b0;
      req_data   <= '0;
      victim_tag <= '0;
      cnt        <= '0;
      phase      <= 1'b0;
      replay     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (en_r || en_w) begin
            req_addr <= addr;
            req_type <= u_b_h_w;
            req_w    <= en_w;
            req_data <= data_w;
            replay   <= 1'b0;
          end
        end
        S_CHECK: begin
          if (!cache_hit) begin
            cnt   <= '0;
            phase <= 1'b0;
            if (cache_valid && cache_dirty) victim_tag <= cache_tag;
          end
        end
        // Phase 0 addresses the victim word; phase 1 holds it on mem_dout until memory accepts.
        S_BACK: begin
          if (!phase) begin
            phase <= 1'b1;
          end else if (mem_ack) begin
            phase <= 1'b0;
            cnt   <= cnt + 1'b1;
          end
        end
        S_FILL: begin
          if (mem_ack) cnt <= cnt + 1'b1;
        end
        S_WAIT: replay <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    stall         = 1'b0;
    data_r        = '0;
    cache_addr    = '0;
    cache_load    = 1'b0;
    cache_edit    = 1'b0;
    cache_store   = 1'b0;
    cache_invalid = 1'b0;
    cache_u_b_h_w = '0;
    cache_din     = '0;
    mem_cs        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_dout      = '0;
    if (rst) begin
      state_nxt = S_IDLE;
      // A half-filled victim way would look valid with stale words, so the whole set is dropped.
      if (state == S_FILL) begin
        cache_invalid = 1'b1;
        cache_addr    = req_addr;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (en_r || en_w) begin
            stall         = 1'b1;
            cache_addr    = addr;
            cache_load    = en_r;
            cache_edit    = en_w;
            cache_din     = data_w;
            cache_u_b_h_w = u_b_h_w;
            state_nxt     = S_CHECK;
          end
        end
        S_CHECK: begin
          cache_addr    = req_addr;
          cache_u_b_h_w = req_type;
          if (cache_hit) begin
            data_r    = req_w ? '0 : cache_dout;
            state_nxt = S_IDLE;
          end else begin
            stall     = 1'b1;
            state_nxt = (cache_valid && cache_dirty) ? S_BACK : S_FILL;
          end
        end
        S_BACK: begin
          stall         = 1'b1;
          cache_addr    = back_addr;
          cache_u_b_h_w = WIDTH_WORD;
          if (phase) begin
            mem_cs   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = back_addr;
            mem_dout = cache_dout;
            if (mem_ack && cnt == CNT_LAST) state_nxt = S_FILL;
          end
        end
        S_FILL: begin
          stall         = 1'b1;
          mem_cs        = 1'b1;
          mem_addr      = fill_addr;
          cache_addr    = fill_addr;
          cache_u_b_h_w = WIDTH_WORD;
          if (mem_ack) begin
            cache_store = 1'b1;
            cache_din   = mem_din;
            if (cnt == CNT_LAST) state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          stall         = 1'b1;
          cache_addr    = req_addr;
          cache_load    = ~req_w;
          cache_edit    = req_w;
          cache_din     = req_data;
          cache_u_b_h_w = req_type;
          state_nxt     = S_CHECK;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef CMU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      // The replay after a refill always hits; it is the tail of a miss, not a hit.
      if (state == S_CHECK && cache_hit && !replay) hit_cnt <= hit_cnt + 32'd1;
      if (state == S_CHECK && !cache_hit) miss_cnt <= miss_cnt + 32'd1;
      if (state == S_BACK && phase && mem_ack && cnt == CNT_LAST) wb_cnt <= wb_cnt + 32'd1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
  assign wb_cnt   = '0;
`endif

endmodule

// File: tb/tb_cache_mgmt_unit.sv
// Bench for cache_mgmt_unit: behavioural 2-way cache and memory around the DUT, scoreboard for loads and beats.
module tb_cache_mgmt_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_r, en_w;
  logic [31:0] addr;
  logic [2:0]  u_b_h_w;
  logic [31:0] data_w, data_r;
  logic        stall;
  logic [31:0] cache_addr;
  logic        cache_load, cache_edit, cache_store, cache_invalid;
  logic [2:0]  cache_u_b_h_w;
  logic [31:0] cache_din;
  logic        cache_hit;
  logic [31:0] cache_dout;
  logic        cache_valid, cache_dirty;
  logic [22:0] cache_tag;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        mem_ack;
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;

  always #5 clk = ~clk;

  cache_mgmt_unit dut (
    .clk(clk), .rst(rst), .en_r(en_r), .en_w(en_w), .addr(addr), .u_b_h_w(u_b_h_w),
    .data_w(data_w), .data_r(data_r), .stall(stall), .cache_addr(cache_addr),
    .cache_load(cache_load), .cache_edit(cache_edit), .cache_store(cache_store),
    .cache_invalid(cache_invalid), .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din),
    .cache_hit(cache_hit), .cache_dout(cache_dout), .cache_valid(cache_valid),
    .cache_dirty(cache_dirty), .cache_tag(cache_tag), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

`ifdef CMU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_mem[$];
  logic [31:0] exp_rd[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_beats = 0;
  int          n_store = 0;
  int          ack_delay = 0;
  logic [31:0] mem [bit [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] b, input logic [2:0] t);
    logic [7:0]  by;
    logic [15:0] hf;
    by = w[b*8 +: 8];
    hf = b[1] ? w[31:16] : w[15:0];
    case (t)
      LB:      return {{24{by[7]}}, by};
      LH:      return {{16{hf[15]}}, hf};
      LBU:     return {24'd0, by};
      LHU:     return {16'd0, hf};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [31:0] d, input logic [1:0] b,
                                           input logic [2:0] t);
    logic [31:0] r;
    r = w;
    case (t)
      SB: r[b*8 +: 8] = d[7:0];
      SH: if (b[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // Behavioural cache: registered outputs, LRU refreshed only by load/edit hits, fills go to the LRU way.
  initial begin
    logic [31:0] c_data [32][2][4];
    logic [22:0] c_tag [32][2];
    logic        c_v [32][2];
    logic        c_d [32][2];
    logic        c_lru [32];
    logic [4:0]  st;
    logic [22:0] tg;
    logic [1:0]  wd;
    logic        found, hw, vw;
    for (int s = 0; s < 32; s++) begin
      c_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        c_v[s][w] = 1'b0; c_d[s][w] = 1'b0; c_tag[s][w] = '0;
        for (int k = 0; k < 4; k++) c_data[s][w][k] = '0;
      end
    end
    cache_hit = 1'b0; cache_dout = '0; cache_valid = 1'b0; cache_dirty = 1'b0; cache_tag = '0;
    forever begin
      @(posedge clk);
      st = cache_addr[8:4]; tg = cache_addr[31:9]; wd = cache_addr[3:2];
      found = 1'b0; hw = 1'b0;
      if (c_v[st][0] && c_tag[st][0] == tg) found = 1'b1;
      else if (c_v[st][1] && c_tag[st][1] == tg) begin found = 1'b1; hw = 1'b1; end
      if (cache_invalid) begin
        c_v[st][0] = 1'b0; c_v[st][1] = 1'b0; c_d[st][0] = 1'b0; c_d[st][1] = 1'b0;
        cache_hit <= 1'b0;
      end else if (cache_store) begin
        vw = c_lru[st];
        c_data[st][vw][wd] = cache_din; c_tag[st][vw] = tg; c_v[st][vw] = 1'b1; c_d[st][vw] = 1'b0;
        cache_hit <= 1'b0;
      end else if ((cache_load || cache_edit) && found) begin
        c_lru[st] = ~hw;
        if (cache_edit) begin
          c_data[st][hw][wd] = st_merge(c_data[st][hw][wd], cache_din, cache_addr[1:0], cache_u_b_h_w);
          c_d[st][hw] = 1'b1;
        end
        cache_hit   <= 1'b1;
        cache_valid <= 1'b1;
        cache_dirty <= c_d[st][hw];
        cache_tag   <= tg;
        cache_dout  <= cache_load ? ld_ext(c_data[st][hw][wd], cache_addr[1:0], cache_u_b_h_w)
                                  : c_data[st][hw][wd];
      end else begin
        vw = c_lru[st];
        cache_hit   <= 1'b0;
        cache_dout  <= c_data[st][vw][wd];
        cache_valid <= c_v[st][vw];
        cache_dirty <= c_d[st][vw];
        cache_tag   <= c_tag[st][vw];
      end
    end
  end

  // Memory responder: acks after ack_delay idle cycles, one-cycle pulse, then at least one cycle low.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ack = 1'b0;
    mem_din = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_cs) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_dout;
          else mem_din = mem_rd(mem_addr);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted memory beat and every completed load.
  initial begin
    logic        prev_cs, prev_ack, prev_we;
    logic [31:0] prev_addr;
    beat_t       e;
    prev_cs = 1'b0; prev_ack = 1'b0; prev_we = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_cs && mem_ack) begin
          n_beats++;
          if (exp_mem.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_beat: got addr %h we %0d, expected none", mem_addr, mem_we);
          end else begin
            e = exp_mem.pop_front();
            check("beat_we", 32'(mem_we), 32'(e.we));
            check("beat_addr", mem_addr, e.addr);
            if (e.we) check("beat_wdata", mem_dout, e.data);
          end
        end
        if (en_r && !stall) begin
          if (exp_rd.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_load: got %h, expected none", data_r);
          end else begin
            check("load_data", data_r, exp_rd.pop_front());
          end
        end
        if (mem_cs) begin
          check("mem_align", 32'(mem_addr[1:0]), 32'd0);
          check("stall_in_mem", 32'(stall), 32'd1);
          check("cs_with_edit", 32'(cache_edit), 32'd0);
        end
        if (mem_cs && prev_cs && !prev_ack) begin
          check("held_addr", mem_addr, prev_addr);
          check("held_we", 32'(mem_we), 32'(prev_we));
        end
        if (cache_store) n_store++;
      end
      prev_cs = mem_cs; prev_ack = mem_ack; prev_we = mem_we; prev_addr = mem_addr;
    end
  end

  task automatic push_rd_line(input logic [31:0] base);
    for (int k = 0; k < 4; k++) exp_mem.push_back({1'b0, base + 32'(4 * k), 32'd0});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_mem.push_back({1'b1, a, d});
  endtask

  // Entered just after a rising edge; leaves just after the edge that retires the request.
  task automatic cpu_req(input logic w, input logic [31:0] a, input logic [2:0] t, input logic [31:0] d,
                         output int cyc);
    int k;
    en_r = ~w; en_w = w; addr = a; u_b_h_w = t; data_w = d;
    cyc = 0;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!stall) break;
      cyc++;
    end
    if (k == 300) begin
      n_vec++; n_bad++;
      $display("FAIL req_timeout: addr %h still stalled, expected completion", a);
    end
    @(posedge clk);
    #1;
    en_r = 1'b0; en_w = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, b0, s0, k;
    rst = 1'b1; en_r = 1'b0; en_w = 1'b0; addr = '0; u_b_h_w = '0; data_w = '0;
    for (int i = 0; i < 4; i++) mem[32'h2000 + 32'(4 * i)] = 32'hA0 + 32'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_cs", 32'(mem_cs), 32'd0);
    check("rst_strobes", {28'd0, cache_load, cache_edit, cache_store, cache_invalid}, 32'd0);
    check("rst_data_r", data_r, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: preload line 0x100 through a miss, then a read hit
    push_rd_line(32'h100);
    exp_rd.push_back(32'h0100_FEFF);
    cpu_req(1'b0, 32'h100, LW, 32'd0, cyc);
    b0 = n_beats;
    exp_rd.push_back(32'h0104_FEFB);
    cpu_req(1'b0, 32'h104, LW, 32'd0, cyc);
    check("t1_hit_stall_cycles", 32'(cyc), 32'd1);
    check("t1_no_mem", 32'(n_beats - b0), 32'd0);

    // 2: clean miss, byte load after refill
    s0 = n_store;
    push_rd_line(32'h2000);
    exp_rd.push_back(32'h0000_00A0);
    cpu_req(1'b0, 32'h2000, LBU, 32'd0, cyc);
    check("t2_store_pulses", 32'(n_store - s0), 32'd4);

    // 3: dirty victim in set 16 is written back before the refill
    cpu_req(1'b1, 32'h100, SW, 32'hDEAD_BEEF, cyc);
    push_rd_line(32'h300);
    exp_rd.push_back(32'h0300_FCFF);
    cpu_req(1'b0, 32'h300, LW, 32'd0, cyc);
    push_wr(32'h100, 32'hDEAD_BEEF);
    push_wr(32'h104, 32'h0104_FEFB);
    push_wr(32'h108, 32'h0108_FEF7);
    push_wr(32'h10C, 32'h010C_FEF3);
    push_rd_line(32'h700);
    exp_rd.push_back(32'h0700_F8FF);
    cpu_req(1'b0, 32'h700, LW, 32'd0, cyc);
    check("t3_wb_cnt", wb_cnt, PERF ? 32'd1 : 32'd0);

    // 4: write miss, replayed halfword store
    push_rd_line(32'h400);
    cpu_req(1'b1, 32'h402, SH, 32'h0000_1234, cyc);
    exp_rd.push_back(32'h1234_FBFF);
    cpu_req(1'b0, 32'h400, LW, 32'd0, cyc);

    // 5: slow memory, signed halfword
    ack_delay = 5;
    s0 = n_store;
    push_rd_line(32'h810);
    exp_rd.push_back(32'hFFFF_F7EF);
    cpu_req(1'b0, 32'h810, LH, 32'd0, cyc);
    ack_delay = 0;
    check("t5_store_pulses", 32'(n_store - s0), 32'd4);
    check("t5_long_stall", 32'(cyc >= 24), 32'd1);
    check("t5_hit_cnt", hit_cnt, PERF ? 32'd3 : 32'd0);
    check("t5_miss_cnt", miss_cnt, PERF ? 32'd6 : 32'd0);

    // 6: reset during the second fill beat invalidates set 0
    exp_mem.push_back({1'b0, 32'h0C00, 32'd0});
    en_r = 1'b1; addr = 32'h0C00; u_b_h_w = LW;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cache_store) break;
    end
    if (k == 100) begin
      n_vec++; n_bad++;
      $display("FAIL t6_first_store: no fill beat seen, expected one");
    end
    @(posedge clk); #1;
    rst = 1'b1; en_r = 1'b0;
    @(negedge clk);
    check("t6_invalid", 32'(cache_invalid), 32'd1);
    check("t6_invalid_addr", cache_addr, 32'h0C00);
    check("t6_no_mem_cs", 32'(mem_cs), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_idle_stall", 32'(stall), 32'd0);
    check("t6_miss_cnt_clr", miss_cnt, 32'd0);
    check("t6_wb_cnt_clr", wb_cnt, 32'd0);
    @(posedge clk); #1;
    s0 = n_store;
    push_rd_line(32'h2000);
    exp_rd.push_back(32'h0000_00A0);
    cpu_req(1'b0, 32'h2000, LBU, 32'd0, cyc);
    check("t6_reread_fill", 32'(n_store - s0), 32'd4);
    check("t6_miss_cnt", miss_cnt, PERF ? 32'd1 : 32'd0);

    repeat (3) @(posedge clk);
    check("left_mem_beats", 32'(exp_mem.size()), 32'd0);
    check("left_loads", 32'(exp_rd.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
